// File: rtl/sh4a_regfile_banked.sv
// ============================================================================
// sh4a_regfile_banked: SH4A general registers with SR.RB banking of the low
// registers, a hardwired zero index, two registered read ports, one write
// port and a halfword-stepping PC. A clear sweep zeroes storage after reset.
// Option macro: SH4A_REGFILE_BYPASS_EN (write-first same-cycle forwarding).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sh4a_regfile_banked #(
  parameter int                DATA_W      = 32,
  parameter int                IDX_W       = 5,
  parameter int                NUM_REGS    = 24,
  parameter int                BANKED_REGS = 8,
  parameter int                ZERO_IDX    = 'h17,
  parameter logic [DATA_W-1:0] RESET_PC    = 32'hA000_0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              bank_sel,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  idx_read0,
  input  logic [IDX_W-1:0]  idx_read1,
  input  logic              alt_read0,
  output logic [DATA_W-1:0] reg_read0,
  output logic [DATA_W-1:0] reg_read1,
  input  logic [IDX_W-1:0]  idx_write,
  input  logic              alt_write,
  input  logic [DATA_W-1:0] reg_write,
  input  logic              reg_write_enable,
  input  logic              pc_load,
  input  logic [DATA_W-1:0] pc_target,
  input  logic              pc_advance,
  output logic [DATA_W-1:0] program_counter
);

  localparam int PHYS_REGS = NUM_REGS + BANKED_REGS;
  localparam int PTR_W     = $clog2(PHYS_REGS);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              clearing;
  logic [PTR_W-1:0]  clr_ptr;
  logic [DATA_W-1:0] regs [PHYS_REGS];

  logic [PTR_W-1:0]  wr_phys;
  logic [PTR_W-1:0]  rd0_phys;
  logic [PTR_W-1:0]  rd1_phys;
  logic              wr_ok;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;

  // Bank-1 copies of the low registers live above the shared entries.
  function automatic logic [PTR_W-1:0] phys_of(input logic [IDX_W-1:0] idx,
                                               input logic bank);
    if (bank && (int'(idx) < BANKED_REGS))
      return PTR_W'(NUM_REGS + int'(idx));
    return PTR_W'(idx);
  endfunction

  function automatic logic live(input logic [IDX_W-1:0] idx);
    return (int'(idx) < NUM_REGS) && (int'(idx) != ZERO_IDX);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: if (clr_ptr == PTR_W'(PHYS_REGS - 1)) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_CLEAR;
    endcase
  end

  always_comb begin
    ready    = (state == S_RUN);
    clearing = (state == S_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         clr_ptr <= '0;
    else if (clearing) clr_ptr <= clr_ptr + 1'b1;
  end

  assign wr_phys  = phys_of(idx_write, bank_sel ^ alt_write);
  assign rd0_phys = phys_of(idx_read0, bank_sel ^ alt_read0);
  assign rd1_phys = phys_of(idx_read1, bank_sel);
  assign wr_ok    = ready && reg_write_enable && live(idx_write);

  always_ff @(posedge clk) begin
    if (clearing)   regs[clr_ptr] <= '0;
    else if (wr_ok) regs[wr_phys] <= reg_write;
  end

  always_comb begin
    rd0_data = live(idx_read0) ? regs[rd0_phys] : '0;
    rd1_data = live(idx_read1) ? regs[rd1_phys] : '0;
`ifdef SH4A_REGFILE_BYPASS_EN
    // Forward on physical-entry match only, so banks never alias.
    if (wr_ok && live(idx_read0) && (wr_phys == rd0_phys)) rd0_data = reg_write;
    if (wr_ok && live(idx_read1) && (wr_phys == rd1_phys)) rd1_data = reg_write;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_read0 <= '0;
      reg_read1 <= '0;
    end else if (clearing) begin
      reg_read0 <= '0;
      reg_read1 <= '0;
    end else if (rd_en) begin
      reg_read0 <= rd0_data;
      reg_read1 <= rd1_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      program_counter <= RESET_PC;
    end else if (ready) begin
      if (pc_load)         program_counter <= {pc_target[DATA_W-1:1], 1'b0};
      else if (pc_advance) program_counter <= program_counter + DATA_W'(2);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sh4a_regfile_banked.sv
// ============================================================================
// tb_sh4a_regfile_banked: directed and randomized checks of the banked
// register file against a logical-register reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sh4a_regfile_banked;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        bank_sel, rd_en, alt_read0, alt_write, reg_write_enable;
  logic        pc_load, pc_advance;
  logic [4:0]  idx_read0, idx_read1, idx_write;
  logic [31:0] reg_read0, reg_read1, reg_write, pc_target, program_counter;

  always #5 clk = ~clk;

  sh4a_regfile_banked dut (
    .clk(clk), .reset(reset), .ready(ready), .bank_sel(bank_sel), .rd_en(rd_en),
    .idx_read0(idx_read0), .idx_read1(idx_read1), .alt_read0(alt_read0),
    .reg_read0(reg_read0), .reg_read1(reg_read1), .idx_write(idx_write),
    .alt_write(alt_write), .reg_write(reg_write), .reg_write_enable(reg_write_enable),
    .pc_load(pc_load), .pc_target(pc_target), .pc_advance(pc_advance),
    .program_counter(program_counter)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Logical view: m[bank][idx]; registers 8..23 are kept equal in both banks.
  logic [31:0] m [0:1][0:31];
  logic [31:0] exp_r0, exp_r1, exp_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [31:0] mread(input int idx, input bit bank);
    if (idx >= 24 || idx == 23) return 32'h0;
    return m[bank][idx];
  endfunction

  task automatic mwrite();
    int idx = int'(idx_write);
    bit b   = bank_sel ^ alt_write;
    if (!reg_write_enable || idx >= 24 || idx == 23) return;
    if (idx < 8) m[b][idx] = reg_write;
    else begin
      m[0][idx] = reg_write;
      m[1][idx] = reg_write;
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) m[b][i] = 32'h0;
    exp_r0 = 32'h0;
    exp_r1 = 32'h0;
    exp_pc = 32'hA000_0000;
  endtask

  task automatic idle();
    rd_en = 0; alt_read0 = 0; alt_write = 0; reg_write_enable = 0;
    pc_load = 0; pc_advance = 0; idx_read0 = 0; idx_read1 = 0; idx_write = 0;
    reg_write = 0; pc_target = 0;
  endtask

  // One RUN-mode cycle: predict, clock, compare; returns at the next negedge.
  task automatic tick(input string tag);
`ifdef SH4A_REGFILE_BYPASS_EN
    mwrite();
`endif
    if (rd_en) begin
      exp_r0 = mread(int'(idx_read0), bank_sel ^ alt_read0);
      exp_r1 = mread(int'(idx_read1), bank_sel);
    end
`ifndef SH4A_REGFILE_BYPASS_EN
    mwrite();
`endif
    if (pc_load) exp_pc = {pc_target[31:1], 1'b0};
    else if (pc_advance) exp_pc = exp_pc + 32'd2;
    @(posedge clk); #1;
    check({tag, "/r0"}, reg_read0, exp_r0);
    check({tag, "/r1"}, reg_read1, exp_r1);
    check({tag, "/pc"}, program_counter, exp_pc);
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
  endtask

  task automatic wr(input bit b, input int idx, input logic [31:0] d);
    idle(); bank_sel = b; reg_write_enable = 1; idx_write = 5'(idx); reg_write = d;
  endtask

  task automatic rd(input bit b, input bit alt, input int i0, input int i1);
    idle(); bank_sel = b; rd_en = 1; alt_read0 = alt;
    idx_read0 = 5'(i0); idx_read1 = 5'(i1);
  endtask

  initial begin
    int n;
    idle(); bank_sel = 0;
    reset = 1;
    model_reset();
    #1;
    check("rst/ready", {31'b0, ready}, 32'h0);
    check("rst/r0", reg_read0, 32'h0);
    check("rst/r1", reg_read1, 32'h0);
    check("rst/pc", program_counter, 32'hA000_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    wait_ready(n);
    check("sweep_cycles", n, 32);

    for (int i = 0; i < 32; i++) begin
      rd(i[0], i[1], i, 31 - i);
      tick("clear_read");
    end

    wr(0, 3, 32'h1111_1111);  tick("w_r3_b0");
    wr(1, 3, 32'h2222_2222);  tick("w_r3_b1");
    wr(1, 12, 32'hABCD_1234); tick("w_r12");
    rd(0, 0, 3, 12);  tick("rd_b0");
    check("r3_b0", reg_read0, 32'h1111_1111);
    check("r12_b0", reg_read1, 32'hABCD_1234);
    rd(0, 1, 3, 3);   tick("rd_alt");
    check("r3_alt", reg_read0, 32'h2222_2222);
    check("r3_b0_p1", reg_read1, 32'h1111_1111);
    rd(1, 0, 12, 3);  tick("rd_b1");
    check("r12_b1", reg_read0, 32'hABCD_1234);
    check("r3_b1", reg_read1, 32'h2222_2222);

    wr(0, 23, 32'hDEAD_BEEF); tick("w_zero");
    wr(1, 30, 32'h5);         tick("w_oor");
    rd(1, 0, 23, 30); tick("rd_zero");
    check("zero_idx", reg_read0, 32'h0);
    check("idx30", reg_read1, 32'h0);

    wr(0, 5, 32'h1); tick("w_r5");
    wr(0, 5, 32'hCAFE_F00D); rd_en = 1; idx_read0 = 5; idx_read1 = 5;
    tick("same_cycle");
`ifdef SH4A_REGFILE_BYPASS_EN
    check("same_cycle_r5", reg_read0, 32'hCAFE_F00D);
`else
    check("same_cycle_r5", reg_read0, 32'h1);
`endif
    rd(0, 0, 5, 5); tick("next_cycle");
    check("next_cycle_r5", reg_read1, 32'hCAFE_F00D);

    idle();
    pc_advance = 1;
    repeat (3) tick("pc_adv");
    check("pc_adv3", program_counter, 32'hA000_0006);
    pc_load = 1; pc_target = 32'h8C00_0011; tick("pc_load");
    check("pc_load_odd", program_counter, 32'h8C00_0010);
    idle(); pc_load = 1; pc_target = 32'hFFFF_FFFE; tick("pc_top");
    idle(); pc_advance = 1; tick("pc_wrap");
    check("pc_wrap", program_counter, 32'h0);

    for (int k = 0; k < 400; k++) begin
      idle();
      bank_sel         = 1'($urandom);
      rd_en            = ($urandom_range(0, 3) != 0);
      alt_read0        = 1'($urandom);
      idx_read0        = 5'($urandom_range(0, 31));
      idx_read1        = ($urandom_range(0, 3) == 0) ? idx_write : 5'($urandom_range(0, 31));
      alt_write        = 1'($urandom);
      idx_write        = 5'($urandom_range(0, 25));
      reg_write        = $urandom;
      reg_write_enable = 1'($urandom);
      if ($urandom_range(0, 2) == 0) idx_read0 = idx_write;
      pc_load          = ($urandom_range(0, 15) == 0);
      pc_target        = $urandom;
      pc_advance       = 1'($urandom);
      tick("rand");
    end

    wr(0, 7, 32'h1234_5678); tick("w_r7");
    rd(0, 0, 7, 7); tick("rd_r7");
    check("r7_before_reset", reg_read0, 32'h1234_5678);
    wr(0, 9, 32'h55);
    #2 reset = 1;
    #1;
    check("async_r0", reg_read0, 32'h0);
    check("async_r1", reg_read1, 32'h0);
    check("async_pc", program_counter, 32'hA000_0000);
    check("async_ready", {31'b0, ready}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    reset = 0;
    model_reset();
    wait_ready(n);
    check("resweep_cycles", n, 32);
    rd(0, 0, 7, 9); tick("after_reset");
    check("r7_gone", reg_read0, 32'h0);
    check("r9_gone", reg_read1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sh4a_regfile_banked.md
# sh4a_regfile_banked

Parametrised SH4A general-register file with SR.RB-style banking of the low registers, a hardwired zero register, two registered read ports, one write port and a halfword-stepping program counter. It sits between decode (read/write indices) and execute (operands, writeback). A post-reset clear sweep zeroes every physical entry before the file reports ready.

## Interface
- DATA_W, 32: register and PC width.
- IDX_W, 5: logical index width.
- NUM_REGS, 24: logical registers 0..NUM_REGS-1.
- BANKED_REGS, 8: logical 0..BANKED_REGS-1 are duplicated in bank 1. Must be < ZERO_IDX.
- ZERO_IDX, 0x17: hardwired-zero logical index. Must be < NUM_REGS.
- RESET_PC, 32'hA000_0000: PC value at reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- ready  out  1  high once the clear sweep is done.
- bank_sel  in  1  current bank (SR.RB).
- rd_en  in  1  update both read outputs this cycle.
- idx_read0, idx_read1  in  IDX_W  read indices.
- alt_read0  in  1  read port 0 uses the opposite bank (STC Rn_BANK).
- reg_read0, reg_read1  out  DATA_W  registered read data.
- idx_write  in  IDX_W  write index.
- alt_write  in  1  write uses the opposite bank (LDC Rm_BANK).
- reg_write  in  DATA_W  write data.
- reg_write_enable  in  1  write strobe.
- pc_load  in  1  load pc_target.
- pc_target  in  DATA_W  branch target.
- pc_advance  in  1  step the PC by 2.
- program_counter  out  DATA_W  current PC.

## Operation
- Physical storage holds NUM_REGS+BANKED_REGS entries.
- Effective bank is bank_sel XOR alt flag.
- Logical idx < BANKED_REGS with effective bank 1 maps to physical NUM_REGS+idx. All other indices map to physical idx.
- FSM has two states, CLEAR and RUN.
- Reset forces CLEAR with sweep pointer 0.
- In CLEAR, each cycle writes 0 to physical[pointer] and increments the pointer.
- CLEAR goes to RUN after the last entry, NUM_REGS+BANKED_REGS cycles after reset deasserts. Default is 32 cycles.
- ready = (state == RUN).
- In CLEAR, reg_write_enable, rd_en, pc_load and pc_advance are ignored. Read outputs hold 0.
- Writes in RUN take effect when reg_write_enable is high and idx_write is < NUM_REGS and not ZERO_IDX. Other writes are dropped silently.
- Reads in RUN with rd_en high:
  - Each output loads the mapped entry.
  - ZERO_IDX or idx >= NUM_REGS loads 0.
  - alt_read0 affects port 0 only.
- Reads with rd_en low hold the previous outputs.
- PC in RUN:
  - pc_load: PC <= pc_target with bit 0 cleared.
  - Else pc_advance: PC <= PC+2, wrapping modulo 2^DATA_W.
  - Else PC holds.
  - pc_load wins when both are high.

## Timing
- Reset values: ready=0, reg_read0=reg_read1=0, program_counter=RESET_PC, state CLEAR.
- Assertion mid-operation aborts everything immediately and restarts the sweep.
- Read latency is 1 cycle: index at edge N, data valid after edge N.
- Write is visible to a read issued in the following cycle.
- A same-cycle read of the same physical entry is governed by Configuration.
- Bank switching:
  - A bank_sel change applies to indices presented in that same cycle.
  - Writes in flight are mapped with the bank_sel value at their edge.
- PC update takes effect 1 cycle after the request.
- program_counter is the register output, with no combinational path from the inputs.

## Configuration
- SH4A_REGFILE_BYPASS_EN defined: a read whose physical entry matches a same-cycle valid write returns reg_write (write-first). This uses physical-entry matching, so bank 0 R3 does not forward to bank 1 R3.
- Undefined: the same-cycle read returns the old contents (read-first).

## Test plan
- Reset, then wait: ready rises exactly 32 cycles after reset falls, program_counter=0xA0000000, and every index reads 0.
- bank_sel=0: write R3=0x11111111. bank_sel=1: write R3=0x22222222. Read R3 with bank_sel=0 -> 0x11111111. Read with bank_sel=0, alt_read0=1 -> 0x22222222. R12 reads the same value in both banks.
- Write ZERO_IDX=0xDEADBEEF and idx 30=0x5 -> both ignored; reading ZERO_IDX and idx 30 returns 0.
- Same-cycle write R5=0xCAFEF00D with read R5 (prior value 0x1) -> 0xCAFEF00D with the macro, 0x1 without it. The next cycle returns 0xCAFEF00D in both builds.
- PC sequence:
  - pc_advance x3 -> 0xA0000006.
  - pc_load target 0x8C000011 with pc_advance -> 0x8C000010.
  - pc_load 0xFFFFFFFE then advance -> 0x00000000.
- Reset asserted mid-RUN during a write -> outputs zero and PC=RESET_PC asynchronously, the sweep reruns, and the earlier write is gone (reads 0).
